// File: rtl/fifo_window_reader_pkg.sv
// Shared state encoding and window-count helpers for the FIFO window reader.
// Helpers are functions so each instance can size its counters from its own RowLen.
package fifo_window_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DefRowLen   = 8;
    localparam int WinPerRowS1 = DefRowLen - 1;
    localparam int WinPerRowS2 = DefRowLen / 2;
    localparam int WinCntWidth = $clog2(DefRowLen);

    function automatic int win_per_row_s1(input int row_len);
        return row_len - 32'sd1;
    endfunction

    function automatic int win_per_row_s2(input int row_len);
        return row_len / 32'sd2;
    endfunction

    function automatic int win_cnt_width(input int row_len);
        return $clog2(row_len);
    endfunction

endpackage

// File: rtl/window_out_reg.sv
// Valid/ready output register for one 2-element operand window.
// A load always wins; otherwise an accepted window clears valid and a stalled one holds.
module window_out_reg
    import fifo_window_reader_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 aclr_n,
    input  logic                 load,
    input  logic [DataWidth-1:0] next_a,
    input  logic [DataWidth-1:0] next_b,
    input  logic                 next_last,
    input  logic                 ready,
    output logic                 valid,
    output logic [DataWidth-1:0] a,
    output logic [DataWidth-1:0] b,
    output logic                 last
);

    // Window register: load, drain on acceptance, or hold under back-pressure.
    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            valid <= 1'b0;
            a     <= {DataWidth{1'b0}};
            b     <= {DataWidth{1'b0}};
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            a     <= next_a;
            b     <= next_b;
            last  <= next_last;
        end else if (ready) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/fifo_window_reader.sv
// Drains FIFO_Buffer through its dual-head read port and streams 2-element
// operand windows (stride-1 sliding or stride-2 disjoint) that never cross a row.
module fifo_window_reader
    import fifo_window_reader_pkg::*;
#(
    parameter int DataWidth   = 32,
    parameter int BufferSize  = 16,
    parameter int RowLen      = 8,
    parameter int RowCntWidth = 8
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   Start,
    input  logic                   Stride2,
    input  logic [RowCntWidth-1:0] NumRows,
    output logic                   Busy,
    output logic                   Done,
    input  logic                   Empty,
    input  logic [BufferSize-1:0]  ReadyM,
    input  logic [DataWidth-1:0]   DataIn1,
    input  logic [DataWidth-1:0]   DataIn2,
    output logic                   Pop1,
    output logic                   Pop2,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [DataWidth-1:0]   OutA,
    output logic [DataWidth-1:0]   OutB,
    output logic                   OutLast
);

    localparam int CntW = win_cnt_width(RowLen);
    localparam logic [CntW-1:0]        LastWinS1 = CntW'(win_per_row_s1(RowLen) - 1);
    localparam logic [CntW-1:0]        LastWinS2 = CntW'(win_per_row_s2(RowLen) - 1);
    localparam logic [CntW-1:0]        WinOne    = CntW'(1);
    localparam logic [RowCntWidth-1:0] RowOne    = RowCntWidth'(1);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CntW-1:0]        win_cnt_r;
    logic [RowCntWidth-1:0] row_cnt_r;
    logic [RowCntWidth-1:0] num_rows_r;
    logic                   stride2_r;
    logic                   busy_r;
    logic                   done_r;

    logic                   out_valid_s;
    logic                   slot_free_s;
    logic                   have1_s;
    logic                   have2_s;
    logic                   start_ok_s;
    logic                   last_win_s;
    logic                   last_row_s;
    logic                   drain_ok_s;
    logic                   fire_s;
    logic                   flush_pop_s;
    logic                   unused_ready_s;

    // Only the two head valid bits matter; Empty is folded in so no pop can hit an empty FIFO.
    assign slot_free_s    = !out_valid_s || OutReady;
    assign have2_s        = ReadyM[1] && !Empty;
    assign have1_s        = ReadyM[0] && !Empty;
    assign unused_ready_s = &{1'b0, ReadyM[BufferSize-1:2]};

    assign start_ok_s = Start && !busy_r && (state_r == IDLE);
    assign last_win_s = stride2_r ? (win_cnt_r == LastWinS2) : (win_cnt_r == LastWinS1);
    assign last_row_s = (row_cnt_r + RowOne) == num_rows_r;
    assign drain_ok_s = slot_free_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = (NumRows == {RowCntWidth{1'b0}}) ? DRAIN : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (fire_s && last_win_s) begin
                    // Stride-1 leaves the row's last element in the FIFO; it must be dropped.
                    if (!stride2_r) begin
                        state_nxt_s = FLUSH;
                    end else if (last_row_s) begin
                        state_nxt_s = DRAIN;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FLUSH: begin
                if (flush_pop_s) begin
                    state_nxt_s = last_row_s ? DRAIN : RUN;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            DRAIN: begin
                if (drain_ok_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Per-state pop/load strobes, forced low while reset is asserted.
    always_comb begin
        fire_s      = 1'b0;
        flush_pop_s = 1'b0;
        if (aclr_n) begin
            case (state_r)
                RUN: begin
                    fire_s = slot_free_s && have2_s;
                end
                FLUSH: begin
                    flush_pop_s = have1_s;
                end
                default: begin
                    fire_s      = 1'b0;
                    flush_pop_s = 1'b0;
                end
            endcase
        end else begin
            fire_s      = 1'b0;
            flush_pop_s = 1'b0;
        end
    end

    assign Pop1 = fire_s || flush_pop_s;
    assign Pop2 = fire_s && stride2_r;

    // Job configuration capture and window/row counters.
    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            stride2_r  <= 1'b0;
            num_rows_r <= {RowCntWidth{1'b0}};
            win_cnt_r  <= {CntW{1'b0}};
            row_cnt_r  <= {RowCntWidth{1'b0}};
        end else if (start_ok_s) begin
            stride2_r  <= Stride2;
            num_rows_r <= NumRows;
            win_cnt_r  <= {CntW{1'b0}};
            row_cnt_r  <= {RowCntWidth{1'b0}};
        end else if (fire_s) begin
            if (last_win_s) begin
                win_cnt_r <= {CntW{1'b0}};
                row_cnt_r <= stride2_r ? (row_cnt_r + RowOne) : row_cnt_r;
            end else begin
                win_cnt_r <= win_cnt_r + WinOne;
            end
        end else if (flush_pop_s) begin
            row_cnt_r <= row_cnt_r + RowOne;
        end else begin
            win_cnt_r <= win_cnt_r;
            row_cnt_r <= row_cnt_r;
        end
    end

    // Busy spans accepted Start through the Done cycle; Done pulses once the last window leaves.
    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == DRAIN) && drain_ok_s;
            if (start_ok_s) begin
                busy_r <= 1'b1;
            end else if (done_r) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    assign Busy     = busy_r;
    assign Done     = done_r;
    assign OutValid = out_valid_s;

    window_out_reg #(
        .DataWidth (DataWidth)
    ) u_window_out_reg (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .load      (fire_s),
        .next_a    (DataIn1),
        .next_b    (DataIn2),
        .next_last (last_win_s),
        .ready     (OutReady),
        .valid     (out_valid_s),
        .a         (OutA),
        .b         (OutB),
        .last      (OutLast)
    );

endmodule

// File: tb/tb_fifo_window_reader.sv
// Directed bench for fifo_window_reader: a queue-based FIFO model feeds the DUT,
// a job table drives the main cases, and hand sequences cover reset and NumRows = 0.
module tb_fifo_window_reader;
    import fifo_window_reader_pkg::*;

    localparam int DW  = 32;
    localparam int BS  = 16;
    localparam int RL  = DefRowLen;
    localparam int RCW = 8;

    logic           clk = 1'b0;
    logic           aclr_n;
    logic           Start;
    logic           Stride2;
    logic [RCW-1:0] NumRows;
    logic           Busy;
    logic           Done;
    logic           Empty;
    logic [BS-1:0]  ReadyM;
    logic [DW-1:0]  DataIn1;
    logic [DW-1:0]  DataIn2;
    logic           Pop1;
    logic           Pop2;
    logic           OutValid;
    logic           OutReady;
    logic [DW-1:0]  OutA;
    logic [DW-1:0]  OutB;
    logic           OutLast;

    always #5 clk = ~clk;

    fifo_window_reader #(
        .DataWidth(DW), .BufferSize(BS), .RowLen(RL), .RowCntWidth(RCW)
    ) dut (
        .clk(clk), .aclr_n(aclr_n), .Start(Start), .Stride2(Stride2), .NumRows(NumRows),
        .Busy(Busy), .Done(Done), .Empty(Empty), .ReadyM(ReadyM),
        .DataIn1(DataIn1), .DataIn2(DataIn2), .Pop1(Pop1), .Pop2(Pop2),
        .OutValid(OutValid), .OutReady(OutReady), .OutA(OutA), .OutB(OutB), .OutLast(OutLast)
    );

    typedef struct {
        logic s2;
        int   rows;
        logic tog;
        int   preload;
        int   pushes;
        int   period;
        int   extra_start;
        int   exp_win;
        int   exp_p1;
        int   exp_p2;
        int   exp_resid;
        logic chk_early;
    } job_t;

    job_t jobs[7];

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] wa[$];
    logic [DW-1:0] wb[$];
    logic          wl[$];
    logic [DW-1:0] next_val;
    int  pushes_left, push_period, push_ctr;
    logic toggle_mode;
    int  n_pop1, n_pop2, n_done, v_empty, v_pop2, v_stall, v_early;
    logic prev_stall, prev_last;
    logic [DW-1:0] prev_a, prev_b;
    logic last_p1, last_p2;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        Empty   = (fq.size() == 0);
        for (int i = 0; i < BS; i++) ReadyM[i] = (i < fq.size());
        DataIn1 = (fq.size() > 0) ? fq[0] : 32'h0;
        DataIn2 = (fq.size() > 1) ? fq[1] : 32'h0;
    endtask

    task automatic setup_fifo(input int preload, input logic [DW-1:0] base, input int pushes, input int period);
        fq.delete();
        for (int i = 0; i < preload; i++) fq.push_back(base + DW'(i));
        next_val    = base + DW'(preload);
        pushes_left = pushes;
        push_period = period;
        push_ctr    = 0;
        drive_fifo();
    endtask

    task automatic clear_logs();
        wa.delete(); wb.delete(); wl.delete();
        n_pop1 = 0; n_pop2 = 0; n_done = 0;
        v_empty = 0; v_pop2 = 0; v_stall = 0; v_early = 0;
        prev_stall = 1'b0;
    endtask

    // One clock: observe at the falling edge, then update the FIFO model just after the rising edge.
    task automatic step();
        @(negedge clk);
        if (Pop1 && Empty) v_empty++;
        if (Pop2 && !Pop1) v_pop2++;
        if (Pop1 && fq.size() < 2) v_early++;
        if (prev_stall && (OutA != prev_a || OutB != prev_b || OutLast != prev_last || !OutValid)) v_stall++;
        prev_stall = OutValid && !OutReady;
        prev_a = OutA; prev_b = OutB; prev_last = OutLast;
        if (OutValid && OutReady) begin
            wa.push_back(OutA); wb.push_back(OutB); wl.push_back(OutLast);
        end
        if (Pop1) n_pop1++;
        if (Pop2) n_pop2++;
        if (Done) n_done++;
        last_p1 = Pop1;
        last_p2 = Pop2;
        @(posedge clk);
        #1;
        if (last_p1 && fq.size() > 0) void'(fq.pop_front());
        if (last_p2 && fq.size() > 0) void'(fq.pop_front());
        if (push_period != 0 && pushes_left > 0) begin
            push_ctr++;
            if (push_ctr == push_period) begin
                push_ctr = 0;
                fq.push_back(next_val);
                next_val = next_val + 32'd1;
                pushes_left--;
            end
        end
        OutReady = toggle_mode ? ~OutReady : 1'b1;
        drive_fifo();
    endtask

    task automatic run_and_check(input int id, input logic s2, input int rows, input logic tog,
                                 input int extra_start, input int exp_win, input int exp_p1,
                                 input int exp_p2, input int exp_resid, input logic chk_early);
        int base, k, per, r, c;
        logic [DW-1:0] ea;
        base = (fq.size() > 0) ? int'(fq[0]) : 0;
        clear_logs();
        toggle_mode = tog;
        OutReady = 1'b1;
        Stride2 = s2;
        NumRows = rows[RCW-1:0];
        Start = 1'b1;
        step();
        Start = 1'b0;
        k = 1;
        while (n_done == 0 && k < 2000) begin
            if (extra_start != 0 && k == extra_start) begin
                Start = 1'b1; Stride2 = ~s2; NumRows = 8'd5;
            end else begin
                Start = 1'b0;
            end
            step();
            k++;
        end
        Start = 1'b0;
        check($sformatf("job%0d done_seen", id), (n_done > 0), 1);
        toggle_mode = 1'b0;
        repeat (4) step();
        check($sformatf("job%0d done_pulses", id), n_done, 1);
        check($sformatf("job%0d busy_after", id), Busy, 0);
        check($sformatf("job%0d windows", id), wa.size(), exp_win);
        per = s2 ? WinPerRowS2 : WinPerRowS1;
        for (int j = 0; j < wa.size() && j < exp_win; j++) begin
            r  = j / per;
            c  = j % per;
            ea = DW'(base + r * RL + (s2 ? 2 * c : c));
            check($sformatf("job%0d win%0d a", id, j), wa[j], ea);
            check($sformatf("job%0d win%0d b", id, j), wb[j], ea + 32'd1);
            check($sformatf("job%0d win%0d last", id, j), wl[j], (c == per - 1));
        end
        check($sformatf("job%0d pop1_cycles", id), n_pop1, exp_p1);
        check($sformatf("job%0d pop2_cycles", id), n_pop2, exp_p2);
        check($sformatf("job%0d fifo_residue", id), fq.size(), exp_resid);
        check($sformatf("job%0d pop_while_empty", id), v_empty, 0);
        check($sformatf("job%0d pop2_without_pop1", id), v_pop2, 0);
        check($sformatf("job%0d stall_unstable", id), v_stall, 0);
        if (chk_early) check($sformatf("job%0d pop_before_two", id), v_early, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int k, resid;
        jobs[0] = '{1'b0, 1, 1'b0,  8, 0, 0, 0,  7,  8,  0, 0, 1'b0};
        jobs[1] = '{1'b1, 1, 1'b0,  8, 0, 0, 0,  4,  4,  4, 0, 1'b1};
        jobs[2] = '{1'b0, 2, 1'b1, 16, 0, 0, 0, 14, 16,  0, 0, 1'b0};
        jobs[3] = '{1'b1, 1, 1'b0,  1, 7, 4, 0,  4,  4,  4, 0, 1'b1};
        jobs[4] = '{1'b1, 3, 1'b1, 24, 0, 0, 0, 12, 12, 12, 0, 1'b1};
        jobs[5] = '{1'b0, 1, 1'b0,  1, 7, 3, 0,  7,  8,  0, 0, 1'b0};
        jobs[6] = '{1'b0, 1, 1'b0, 16, 0, 0, 4,  7,  8,  0, 8, 1'b0};

        aclr_n = 1'b0; Start = 1'b0; Stride2 = 1'b0; NumRows = 8'd0;
        OutReady = 1'b1; toggle_mode = 1'b0;
        setup_fifo(8, 32'h0, 0, 0);
        clear_logs();
        step();
        step();
        check("rst busy", Busy, 0);
        check("rst done", Done, 0);
        check("rst outvalid", OutValid, 0);
        check("rst outlast", OutLast, 0);
        check("rst outa", OutA, 0);
        check("rst outb", OutB, 0);
        check("rst pop1", Pop1, 0);
        check("rst pop2", Pop2, 0);
        aclr_n = 1'b1;
        step();
        check("idle pop1", last_p1, 0);

        for (int i = 0; i < 7; i++) begin
            setup_fifo(jobs[i].preload, DW'(32'h1000 * (i + 1)), jobs[i].pushes, jobs[i].period);
            run_and_check(i, jobs[i].s2, jobs[i].rows, jobs[i].tog, jobs[i].extra_start,
                          jobs[i].exp_win, jobs[i].exp_p1, jobs[i].exp_p2, jobs[i].exp_resid,
                          jobs[i].chk_early);
        end

        // NumRows = 0: Busy one cycle alone, then Done with Busy, then both low.
        setup_fifo(4, 32'h50, 0, 0);
        clear_logs();
        Stride2 = 1'b0; NumRows = 8'd0; Start = 1'b1;
        step();
        Start = 1'b0;
        check("nr0 busy c1", Busy, 1);
        check("nr0 done c1", Done, 0);
        step();
        check("nr0 busy c2", Busy, 1);
        check("nr0 done c2", Done, 1);
        step();
        check("nr0 busy c3", Busy, 0);
        check("nr0 done c3", Done, 0);
        check("nr0 pops", n_pop1 + n_pop2, 0);
        check("nr0 fifo", fq.size(), 4);

        // Reset in the middle of a row, then restart from the current head.
        setup_fifo(16, 32'h500, 0, 0);
        clear_logs();
        Stride2 = 1'b0; NumRows = 8'd1; Start = 1'b1;
        step();
        Start = 1'b0;
        k = 0;
        while (wa.size() < 3 && k < 50) begin
            step();
            k++;
        end
        check("midrst three windows", (wa.size() >= 3), 1);
        aclr_n = 1'b0;
        step();
        check("midrst pop1 in reset", last_p1, 0);
        check("midrst pop2 in reset", last_p2, 0);
        check("midrst busy", Busy, 0);
        check("midrst done", Done, 0);
        check("midrst outvalid", OutValid, 0);
        check("midrst outa", OutA, 0);
        check("midrst outb", OutB, 0);
        check("midrst outlast", OutLast, 0);
        aclr_n = 1'b1;
        #1;
        check("midrst idle pop1", Pop1, 0);
        check("midrst idle pop2", Pop2, 0);
        resid = fq.size() - 8;
        run_and_check(7, 1'b0, 1, 1'b0, 0, 7, 8, 0, resid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_window_reader.md
Name: fifo_window_reader

Overview:
Consumer-side controller for FIFO_Buffer. It drains the FIFO through its dual-head read port (Pop1/Pop2, DataOut1/DataOut2, Empty, ReadyM) and emits 2-element operand windows to the convolution PE datapath over a valid/ready stream. It supports stride-1 (sliding) and stride-2 (disjoint) windows, with row boundaries that windows never cross. It is the reader counterpart to the block that pushes into FIFO_Buffer.

Parameters:
DataWidth, 32, width of each FIFO entry and each output operand
BufferSize, 16, FIFO depth; width of ReadyM
RowLen, 8, elements per row; must be at least 2, and even if stride-2 is used
RowCntWidth, 8, width of NumRows

Ports:
clk  in  1  clock; all logic on the rising edge
aclr_n  in  1  reset; synchronous, active-low
Start  in  1  one-cycle pulse that begins a job; ignored while Busy
Stride2  in  1  window mode, sampled on Start: 0 = stride-1, 1 = stride-2
NumRows  in  RowCntWidth  rows in the job, sampled on Start
Busy  out  1  high from the cycle after an accepted Start until the Done cycle, inclusive
Done  out  1  one-cycle pulse at the end of a job
Empty  in  1  FIFO empty flag
ReadyM  in  BufferSize  FIFO valid-entry mask; bit i = entry head+i is valid
DataIn1  in  DataWidth  FIFO DataOut1 (head)
DataIn2  in  DataWidth  FIFO DataOut2 (head+1)
Pop1  out  1  pop the head entry (combinational)
Pop2  out  1  pop the head+1 entry; only ever asserted together with Pop1 (combinational)
OutValid  out  1  output window valid (registered)
OutReady  in  1  downstream accepts the window when OutValid && OutReady
OutA  out  DataWidth  first window element (registered)
OutB  out  DataWidth  second window element (registered)
OutLast  out  1  window is the last of its row (registered)

Behaviour:
- Reset (aclr_n = 0 at a rising edge): state IDLE; Busy, Done, OutValid, OutLast = 0; OutA, OutB = 0; all counters 0. Pop1 and Pop2 are held 0 while aclr_n = 0. Reset mid-job abandons the job; the FIFO is not flushed.
- Definitions:
  - slot_free = !OutValid || OutReady
  - have2 = ReadyM[1]
  - have1 = ReadyM[0] && !Empty
- FSM states: IDLE, RUN, FLUSH, DRAIN.
- IDLE:
  - Start with NumRows = 0: Busy = 1 for one cycle, then Done pulses; no pops.
  - Start with NumRows != 0: go to RUN with WinCnt = 0 and RowCnt = 0.
- RUN, fire = slot_free && have2:
  - On fire, the output register loads OutA = DataIn1, OutB = DataIn2, OutValid = 1 at the same edge.
  - Stride-1: Pop1 = fire, Pop2 = 0; RowLen-1 windows per row.
  - Stride-2: Pop1 = Pop2 = fire; RowLen/2 windows per row.
  - OutLast = 1 on the row's final window. WinCnt increments per fire and clears at end of row.
  - End of row, stride-1: go to FLUSH, because the last row element is still in the FIFO.
  - End of row, stride-2: increment RowCnt; if it was the final row, go to DRAIN, otherwise stay in RUN.
- FLUSH:
  - Pop1 = have1, Pop2 = 0; the popped element is discarded and the output register is untouched.
  - On the pop, increment RowCnt; go to DRAIN if it was the final row, otherwise return to RUN.
- DRAIN: wait until OutValid = 0, or until OutValid && OutReady in the current cycle; then pulse Done and go to IDLE. Busy drops with the Done cycle.
- Output register:
  - Holds OutA, OutB, OutLast stable while OutValid && !OutReady.
  - Clears OutValid on acceptance with no new fire.
  - Back-to-back windows at one per cycle when OutReady is held high.
- Latency: pop edge to OutValid is 0 extra cycles; the window is visible the cycle after the pop edge.
- Invariants:
  - No pop while Empty.
  - Pop2 never without Pop1.
  - No window straddles two rows.
  - Stride2 and NumRows changes during Busy have no effect.
- Starvation: if have2 = 0 in RUN, or have1 = 0 in FLUSH, the FSM holds state with no pops.
- The FIFO may be pushed during the job.

Decomposition:
- Shared package:
  - State encoding localparams: IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3.
  - Window-count helper constants: WinPerRowS1 = RowLen-1, WinPerRowS2 = RowLen/2, WinCntWidth = $clog2(RowLen).
- One sub-module, window_out_reg: the valid/ready output register holding OutA, OutB, OutLast and OutValid, with a load input.
- The FSM and counters stay in the top module.

Test Plan:
1. FIFO preloaded with 0..7, RowLen = 8, NumRows = 1, Stride2 = 0, OutReady = 1:
   - 7 windows (0,1),(1,2)…(6,7); OutLast only on (6,7).
   - Then one flush pop of 7, then Done; 8 Pop1 cycles total, Pop2 never high.
2. Same data, Stride2 = 1:
   - Windows (0,1),(2,3),(4,5),(6,7); Pop1 = Pop2 = 1 on 4 cycles; OutLast on (6,7); no flush.
3. NumRows = 2, stride-1, data 0..15, OutReady toggling 1,0:
   - 14 windows, identical to a 1-cycle-ready run; OutA/OutB stable during each stall.
   - Element 7 discarded between rows; second row starts with (8,9).
4. FIFO holds 1 entry at Start, then 1 push every 4 cycles:
   - No pop until ReadyM[1] = 1; Pop never asserted while Empty = 1.
5. Start with NumRows = 0: Done pulses 2 cycles after Start, no pops. A Start pulse during Busy is ignored: the window count matches a single job.
6. aclr_n driven low mid-row, after 3 windows:
   - Next edge: all outputs 0, state IDLE, Pop1 = Pop2 = 0.
   - A new Start then resumes cleanly from the current FIFO head.
